// File: rtl/dht11_reader_if.sv
// dht11_reader_if: bundle between the DHT11 reader and the rest of the system.
//   i_Start         - read request (rising edge triggers)
//   i_Dht_Line      - raw sensor pad level, asynchronous
//   o_Dht_Drive_Low - 1 = pull the pad to 0, 0 = release to the pull-up
//   o_Data          - last good reading {hum dec, hum int, temp dec, temp int}
//   o_Done          - one-cycle pulse on a successful read
//   o_Error         - one-cycle pulse on timeout or checksum failure
//   o_Busy          - high while a read is in progress
// master: protocol controller / pad side. slave: the reader.
interface dht11_reader_if;
   logic        i_Start;
   logic        i_Dht_Line;
   logic        o_Dht_Drive_Low;
   logic [31:0] o_Data;
   logic        o_Done;
   logic        o_Error;
   logic        o_Busy;

   modport master (
      output i_Start,
      output i_Dht_Line,
      input  o_Dht_Drive_Low,
      input  o_Data,
      input  o_Done,
      input  o_Error,
      input  o_Busy
   );

   modport slave (
      input  i_Start,
      input  i_Dht_Line,
      output o_Dht_Drive_Low,
      output o_Data,
      output o_Done,
      output o_Error,
      output o_Busy
   );
endinterface

// File: rtl/dht11_reader.sv
// dht11_reader: single-wire DHT11 driver. On a rising edge of i_Start it drives
// the host start pulse, follows the sensor response, samples 40 data bits,
// validates the checksum and publishes the reading, pulsing o_Done or o_Error.
// Ports:
//   i_Clock - system clock, all logic on its rising edge
//   i_Reset - synchronous active-high reset
//   bus     - dht11_reader_if.slave (start request, pad, data and status)
module dht11_reader #(
   parameter int unsigned CLK_FREQ_HZ      = 50_000_000,
   parameter int unsigned START_LOW_US     = 18000,
   parameter int unsigned TIMEOUT_US       = 200,
   parameter int unsigned BIT_THRESHOLD_US = 50
) (
   input  logic          i_Clock,
   input  logic          i_Reset,
   dht11_reader_if.slave bus
);

   localparam int unsigned DIV   = CLK_FREQ_HZ / 1_000_000;
   localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

   // Limits are compared one count early together with the tick, so the
   // transition happens on the edge where the counter would reach the limit.
   localparam logic [14:0] START_LIM = 15'(START_LOW_US - 1);
   localparam logic [14:0] TO_LIM    = 15'(TIMEOUT_US - 1);
   localparam logic [14:0] BIT_THR   = 15'(BIT_THRESHOLD_US);

   typedef enum logic [2:0] {
      IDLE,
      START_LOW,
      RELEASE,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      CHECK
   } state_t;

   state_t            state;
   logic [PRE_W-1:0]  pre_cnt;
   logic              tick;
   logic [14:0]       us_cnt;
   logic [2:0]        line_sync;
   logic              line_rise;
   logic              line_fall;
   logic              start_d;
   logic              start_rise;
   logic [39:0]       shift;
   logic [5:0]        bit_cnt;
   logic [7:0]        sum;
   logic              start_reached;
   logic              timed_out;
   logic              bit_value;

   logic              drive_low;
   logic [31:0]       data;
   logic              done;
   logic              error;
   logic              busy;

   // Free-running 1 us prescaler.
   assign tick = (pre_cnt == PRE_W'(DIV - 1));

   always_ff @(posedge i_Clock) begin
      if (i_Reset)   pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + 1'b1;
   end

   // Two synchroniser flops plus one history flop for edge detection.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         line_sync <= '1;
         start_d   <= 1'b0;
      end else begin
         line_sync <= {line_sync[1:0], bus.i_Dht_Line};
         start_d   <= bus.i_Start;
      end
   end

   assign line_rise  = line_sync[1] & ~line_sync[2];
   assign line_fall  = ~line_sync[1] & line_sync[2];
   assign start_rise = bus.i_Start & ~start_d;

   assign start_reached = tick && (us_cnt >= START_LIM);
   assign timed_out     = tick && (us_cnt >= TO_LIM);
   assign bit_value     = (us_cnt > BIT_THR);

   always_comb begin
      sum = shift[39:32] + shift[31:24] + shift[23:16] + shift[15:8];
   end

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state     <= IDLE;
         us_cnt    <= '0;
         shift     <= '0;
         bit_cnt   <= '0;
         drive_low <= 1'b0;
         data      <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
         busy      <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         // Saturating count; any state change below overrides this with a clear.
         if (tick && (us_cnt != '1)) us_cnt <= us_cnt + 1'b1;

         case (state)
            IDLE: begin
               drive_low <= 1'b0;
               busy      <= 1'b0;
               // busy is still high in the Done/Error cycle, which blocks a
               // start edge arriving in that same cycle.
               if (start_rise && !busy) begin
                  state     <= START_LOW;
                  us_cnt    <= '0;
                  shift     <= '0;
                  bit_cnt   <= '0;
                  drive_low <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            START_LOW: begin
               if (start_reached) begin
                  state     <= RELEASE;
                  us_cnt    <= '0;
                  drive_low <= 1'b0;
               end
            end
            RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW: begin
               if (timed_out) begin
                  state     <= IDLE;
                  us_cnt    <= '0;
                  drive_low <= 1'b0;
                  error     <= 1'b1;
               end else if (state == RELEASE && line_fall) begin
                  state  <= RESP_LOW;
                  us_cnt <= '0;
               end else if (state == RESP_LOW && line_rise) begin
                  state  <= RESP_HIGH;
                  us_cnt <= '0;
               end else if (state == RESP_HIGH && line_fall) begin
                  state  <= BIT_LOW;
                  us_cnt <= '0;
               end else if (state == BIT_LOW && line_rise) begin
                  state  <= BIT_HIGH;
                  us_cnt <= '0;
               end
            end
            BIT_HIGH: begin
               if (timed_out) begin
                  state     <= IDLE;
                  us_cnt    <= '0;
                  drive_low <= 1'b0;
                  error     <= 1'b1;
               end else if (line_fall) begin
                  shift   <= {shift[38:0], bit_value};
                  bit_cnt <= bit_cnt + 1'b1;
                  us_cnt  <= '0;
                  state   <= (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
               end
            end
            CHECK: begin
               state  <= IDLE;
               us_cnt <= '0;
               if (sum == shift[7:0]) begin
                  data <= {shift[31:24], shift[39:32], shift[15:8], shift[23:16]};
                  done <= 1'b1;
               end else begin
                  error <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               drive_low <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_Dht_Drive_Low = drive_low;
   assign bus.o_Data          = data;
   assign bus.o_Done          = done;
   assign bus.o_Error         = error;
   assign bus.o_Busy          = busy;

endmodule

// File: doc/dht11_reader.md
# dht11_reader

Single-wire DHT11 driver between the sensor pad and the FPGA protocol controller. On a rising edge of `i_Start` it issues the 18 ms host start pulse, checks the sensor response, and samples 40 data bits. It validates the checksum and presents temperature and humidity in the 32-bit layout the controller consumes, then pulses either `o_Done` or `o_Error`.

## Interface
- `CLK_FREQ_HZ`, 50_000_000: system clock frequency. Must be an integer multiple of 1_000_000.
- `START_LOW_US`, 18000: duration the host drives the line low.
- `TIMEOUT_US`, 200: maximum duration of any single wait phase.
- `BIT_THRESHOLD_US`, 50: a data high pulse longer than this value decodes as 1.
- `i_Clock`, in, 1: system clock. Everything is synchronous to its rising edge.
- `i_Reset`, in, 1: synchronous, active-high reset.
- `i_Start`, in, 1: read request. Only a rising edge triggers; the level is ignored.
- `i_Dht_Line`, in, 1: raw pad input, asynchronous.
- `o_Dht_Drive_Low`, out, 1: 1 means the top level drives the pad to 0; 0 means the pad is released (pull-up).
- `o_Data`, out, 32: [7:0] temp integral, [15:8] temp decimal, [23:16] humidity integral, [31:24] humidity decimal.
- `o_Done`, out, 1: one-cycle pulse on a successful read.
- `o_Error`, out, 1: one-cycle pulse on timeout or checksum failure.
- `o_Busy`, out, 1: high from the accepted start until the cycle of the `o_Done`/`o_Error` pulse, inclusive.

## Operation
- **Input conditioning.** `i_Dht_Line` passes through a 2-flop synchronizer. A third register provides edge detection, so rise and fall are each detected 3 cycles after the pad change.
- **Microsecond tick.** A prescaler of CLK_FREQ_HZ/1_000_000 cycles produces a 1 µs tick. A 15-bit µs counter clears on every state entry and advances on each tick.
- **States:**
  - IDLE: `o_Busy`=0. A start edge goes to START_LOW and clears the shift register and bit count.
  - START_LOW: `o_Dht_Drive_Low`=1. When the counter reaches START_LOW_US, go to RELEASE.
  - RELEASE: drive released. On a falling edge go to RESP_LOW.
  - RESP_LOW: on a rising edge go to RESP_HIGH.
  - RESP_HIGH: on a falling edge go to BIT_LOW.
  - BIT_LOW: on a rising edge go to BIT_HIGH.
  - BIT_HIGH: on a falling edge, shift in (counter > BIT_THRESHOLD_US), MSB first, and increment the bit count. At count 40 go to CHECK; otherwise go to BIT_LOW.
  - CHECK: checksum = (byte0+byte1+byte2+byte3) mod 256, where byte0 is the first byte received.
    - Match: `o_Data` ← {byte1, byte0, byte3, byte2}, pulse `o_Done`, go to IDLE.
    - Mismatch: pulse `o_Error`, go to IDLE.
  - Any state other than IDLE, START_LOW and CHECK: if the counter reaches TIMEOUT_US, pulse `o_Error`, release the line and go to IDLE.
- **Output retention.** `o_Data` changes only on a successful CHECK. After an error it keeps the last good value.
- **Busy behaviour.** Start edges while busy are ignored. The start edge detector still tracks `i_Start`, so a level held high across completion does not retrigger.
- **Same-cycle start.** A start edge in the same cycle as the Done/Error pulse is ignored. A start edge one cycle later is accepted.

## Timing
- **Reset values:** `o_Dht_Drive_Low`=0, `o_Data`=0, `o_Done`=0, `o_Error`=0, `o_Busy`=0, state IDLE, start edge register 0.
- **Reset mid-operation:** takes effect at the next clock edge. The line is released, all outputs go to their reset values (including `o_Data`=0), and no Done/Error pulse is produced.
- **Start latency:** the start edge is accepted on cycle N. `o_Busy` and `o_Dht_Drive_Low` are 1 from N+1.
- **Drive length:** `o_Dht_Drive_Low` stays high for START_LOW_US µs, within ±1 µs of tick phase.
- **Completion latency:** `o_Done`/`o_Error` is registered 1 cycle after CHECK is entered. CHECK lasts 1 cycle.
- **Bit decoding:** nominal sensor bits (26–28 µs high → 0, 70 µs high → 1) decode with margin at the default threshold.
- **Timeout resolution:** 1 µs. The error fires at most TIMEOUT_US+1 µs after the stalled phase begins.

## Test plan
Benches use CLK_FREQ_HZ=1_000_000 and a behavioural sensor model.

1. **Good read.** Sensor sends 0x37 0x00 0x19 0x05 with checksum 0x55 → one `o_Done` pulse, `o_Data`=0x00370519, `o_Error` never asserted, `o_Busy` drops in the Done cycle.
2. **Bad checksum.** Same bytes with checksum 0x54 → one `o_Error` pulse, `o_Data` keeps 0x00370519 from the previous test.
3. **No sensor.** Line stays high → `o_Dht_Drive_Low` high for 18000 µs, then `o_Error` within 201 µs of release, line released.
4. **Stall mid-bit.** Sensor holds the line low after bit 17 → `o_Error` within 201 µs, state returns to IDLE, and the next start edge begins a new read.
5. **Start handling.** `i_Start` held high across a complete read → exactly one read. Extra pulses during busy → ignored. A new rising edge after completion → a second read.
6. **Reset mid-read.** `i_Reset` asserted during START_LOW at 5000 µs → `o_Dht_Drive_Low`=0, `o_Busy`=0 on the next edge, no Done/Error pulse, `o_Data`=0.
